// File: rtl/relu_widen_unpack.sv
// relu_widen_unpack
// Reads packed relu_bound activations (one unsigned (W-1)-bit value per W-bit
// lane) and emits them two at a time as signed 2W-bit elements for the MAC
// datapath. One packed word becomes LANES/2 output beats. A lane whose MSB is
// set was never a legal relu_bound result: it is saturated to 2^(W-1)-1 and
// raises the sticky err flag when its beat is accepted.
module relu_widen_unpack #(
  parameter int W     = 8,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*W-1:0]     out_data,
  output logic               out_last,
  output logic               err,
  input  logic               err_clr
);

  localparam int EW   = 2 * W;
  localparam int HALF = LANES / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(HALF - 1);
  localparam logic [BW-1:0] FIRST_BEAT = BW'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Widen one lane: zero-extend the activation, or saturate an illegal lane.
  function automatic logic [EW-1:0] widen_lane(input logic [W-1:0] lane);
    logic [EW-1:0] elem;
    if (lane[W-1]) begin
      elem = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    end else begin
      elem = {{(W + 1){1'b0}}, lane[W-2:0]};
    end
    return elem;
  endfunction

  // Build the two-element output beat for a given beat index of a word.
  function automatic logic [4*W-1:0] form_beat(input logic [LANES*W-1:0] word,
                                               input logic [BW-1:0]      beat);
    logic [4*W-1:0] res;
    res = {(4 * W){1'b0}};
    for (int e = 0; e < 2; e++) begin
      res[e*EW +: EW] = widen_lane(word[(2 * int'(beat) + e) * W +: W]);
    end
    return res;
  endfunction

  // True when either lane of the selected beat carries an illegal MSB.
  function automatic logic beat_invalid(input logic [LANES*W-1:0] word,
                                        input logic [BW-1:0]      beat);
    logic bad;
    bad = 1'b0;
    for (int e = 0; e < 2; e++) begin
      bad = bad | word[(2 * int'(beat) + e) * W + (W - 1)];
    end
    return bad;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [LANES*W-1:0]   word_r;
  logic                 last_r;
  logic [BW-1:0]        beat_r;
  logic [BW-1:0]        beat_nxt_s;
  logic                 out_valid_r;
  logic [4*W-1:0]       out_data_r;
  logic                 out_last_r;
  logic                 beat_bad_r;
  logic                 err_r;
  logic                 in_ready_s;
  logic                 load_s;
  logic                 advance_s;
  logic                 beat_acc_s;
  logic                 on_last_beat_s;

  assign beat_nxt_s     = beat_r + BW'(1);
  assign on_last_beat_s = (beat_r == LAST_BEAT);
  assign beat_acc_s     = out_valid_r & out_ready;

  // Next-state and handshake decode; in_ready never looks at in_valid.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EMIT: begin
        if (out_ready && on_last_beat_s) begin
          // Word finishes this cycle: a new word may slide in with no bubble.
          in_ready_s = 1'b1;
          if (in_valid) begin
            load_s      = 1'b1;
            state_nxt_s = EMIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (out_ready) begin
          advance_s   = 1'b1;
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; out_valid is registered alongside and tracks EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s == EMIT);
    end
  end

  // Holding register and registered beat outputs; held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r     <= {(LANES * W){1'b0}};
      last_r     <= 1'b0;
      beat_r     <= FIRST_BEAT;
      out_data_r <= {(4 * W){1'b0}};
      out_last_r <= 1'b0;
      beat_bad_r <= 1'b0;
    end else if (load_s) begin
      word_r     <= in_data;
      last_r     <= in_last;
      beat_r     <= FIRST_BEAT;
      out_data_r <= form_beat(in_data, FIRST_BEAT);
      out_last_r <= in_last & (LAST_BEAT == FIRST_BEAT);
      beat_bad_r <= beat_invalid(in_data, FIRST_BEAT);
    end else if (advance_s) begin
      beat_r     <= beat_nxt_s;
      out_data_r <= form_beat(word_r, beat_nxt_s);
      out_last_r <= last_r & (beat_nxt_s == LAST_BEAT);
      beat_bad_r <= beat_invalid(word_r, beat_nxt_s);
    end
  end

  // Sticky error: a newly accepted illegal beat wins over a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (beat_acc_s && beat_bad_r) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign err       = err_r;

endmodule
